// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if
//   Handshake bundle between a pixel source/window sink and conv_window_ctrl.
//   start_i     : frame-start pulse
//   pix_v_i     : upstream pixel valid
//   pix_ready_o : upstream request (transfer = pix_v_i && pix_ready_o)
//   lb_en_o     : line-buffer shift enable (equals the transfer term)
//   win_ready_i : downstream accepts the current window
//   win_v_o     : 3x3 window valid
//   col_o/row_o : window centre coordinates
//   sof_o/eof_o : first/last window of the frame
//   busy_o      : controller not idle
// The slave modport is the controller; master is the source/sink side.
interface conv_window_ctrl_if;
   logic       start_i;
   logic       pix_v_i;
   logic       pix_ready_o;
   logic       lb_en_o;
   logic       win_ready_i;
   logic       win_v_o;
   logic [9:0] col_o;
   logic [8:0] row_o;
   logic       sof_o;
   logic       eof_o;
   logic       busy_o;

   modport master (
      output start_i, pix_v_i, win_ready_i,
      input  pix_ready_o, lb_en_o, win_v_o, col_o, row_o, sof_o, eof_o, busy_o
   );

   modport slave (
      input  start_i, pix_v_i, win_ready_i,
      output pix_ready_o, lb_en_o, win_v_o, col_o, row_o, sof_o, eof_o, busy_o
   );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Raster-scan controller for a 3x3 convolution window fed by line buffers.
//   Counts incoming pixels, primes the first two rows plus two pixels, then
//   issues one window per interior pixel with a valid/ready handshake.
// Ports:
//   clk_i   : clock, all state on rising edge
//   reset_i : synchronous active-high reset
//   ctl     : conv_window_ctrl_if.slave handshake bundle
module conv_window_ctrl #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic               clk_i,
   input  logic               reset_i,
   conv_window_ctrl_if.slave  ctl
);

   localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
   localparam logic [8:0] ROW_LAST = 9'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

   state_t     state, state_nx;
   logic [9:0] in_col;
   logic [8:0] in_row;
   logic       pix_ready;
   logic       xfer;
   logic       in_last;
   logic       win_hit;
   logic       win_v;
   logic [9:0] col;
   logic [8:0] row;
   logic       sof;
   logic       eof;

   assign in_last = (in_col == COL_LAST) && (in_row == ROW_LAST);
   // A window is centred one pixel up-left of the incoming pixel, so only
   // pixels with at least two rows and two columns behind them complete one.
   assign win_hit = (in_col >= 10'd2) && (in_row >= 9'd2);

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      pix_ready = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE:   pix_ready = 1'b0;
         PRIME:  pix_ready = 1'b1;
         // An unaccepted window must stall upstream so it is not overwritten.
         STREAM: pix_ready = !win_v || ctl.win_ready_i;
         DONE:   pix_ready = 1'b0;
         default: pix_ready = 1'b0;
      endcase
      xfer = ctl.pix_v_i && pix_ready;
      case (state)
         IDLE:   if (ctl.start_i) state_nx = PRIME;
         PRIME:  if (xfer && (in_row == 9'd2) && (in_col == 10'd1)) state_nx = STREAM;
         STREAM: if (xfer && in_last) state_nx = DONE;
         // In DONE the only window that can be pending is the eof window.
         DONE:   if (win_v && ctl.win_ready_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         in_col <= '0;
         in_row <= '0;
      end else if (xfer) begin
         if (in_last) begin
            in_col <= '0;
            in_row <= '0;
         end else if (in_col == COL_LAST) begin
            in_col <= '0;
            in_row <= in_row + 9'd1;
         end else begin
            in_col <= in_col + 10'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         win_v <= 1'b0;
         col   <= '0;
         row   <= '0;
         sof   <= 1'b0;
         eof   <= 1'b0;
      end else if (xfer && win_hit) begin
         win_v <= 1'b1;
         col   <= in_col - 10'd1;
         row   <= in_row - 9'd1;
         sof   <= (in_col == 10'd2) && (in_row == 9'd2);
         eof   <= in_last;
      end else if (ctl.win_ready_i) begin
         win_v <= 1'b0;
         sof   <= 1'b0;
         eof   <= 1'b0;
      end
   end

   assign ctl.pix_ready_o = pix_ready;
   assign ctl.lb_en_o     = xfer;
   assign ctl.win_v_o     = win_v;
   assign ctl.col_o       = col;
   assign ctl.row_o       = row;
   assign ctl.sof_o       = sof;
   assign ctl.eof_o       = eof;
   assign ctl.busy_o      = (state != IDLE);

endmodule
